// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-256 key schedule constants, FSM encoding and byte helpers
package aes_pkg;

    localparam int NRK   = 15;
    localparam int NSTEP = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } rks_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Only seven round constants are ever needed with an 8-word key
    function automatic logic [7:0] rcon(input logic [2:0] s);
        case (s)
            3'd0:    return 8'h01;
            3'd1:    return 8'h02;
            3'd2:    return 8'h04;
            3'd3:    return 8'h08;
            3'd4:    return 8'h10;
            3'd5:    return 8'h20;
            3'd6:    return 8'h40;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes256_key_step.sv
// rtl/aes256_key_step.sv - one combinational AES-256 key expansion step (8 words in, 8 words out)
import aes_pkg::*;

module aes256_key_step (
    input  logic [255:0] work,
    input  logic [2:0]   step,
    output logic [255:0] work_nxt
);

    logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
    logic [31:0] n0, n1, n2, n3, n4, n5, n6, n7;
    logic [31:0] t, u;

    assign {w0, w1, w2, w3, w4, w5, w6, w7} = work;

    // First half: rotate + substitute + round constant on the last word
    assign t  = sub_word({w7[23:0], w7[31:24]}) ^ {rcon(step), 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    // Second half: the extra Nk=8 substitution, no rotate and no constant
    assign u  = sub_word(n3);
    assign n4 = w4 ^ u;
    assign n5 = w5 ^ n4;
    assign n6 = w6 ^ n5;
    assign n7 = w7 ^ n6;

    assign work_nxt = {n0, n1, n2, n3, n4, n5, n6, n7};

endmodule

// File: rtl/aes256_round_key_sequencer.sv
// rtl/aes256_round_key_sequencer.sv - iterative AES-256 key schedule with round-key register file
import aes_pkg::*;

module aes256_round_key_sequencer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         zeroize,
    input  logic [255:0] key_in,
    input  logic         rd_rev,
    input  logic [3:0]   rd_idx,
    output logic         busy,
    output logic         done,
    output logic         key_valid,
    output logic [127:0] rd_key
);

    localparam logic [2:0] STEP_LAST = 3'(NSTEP - 1);
    localparam logic [3:0] IDX_LAST  = 4'(NRK - 1);

    rks_state_t   state, state_nxt;
    logic [2:0]   step;
    logic [255:0] work, work_nxt;
    logic [127:0] rk [NRK];
    logic         load, expand_en, step_last;
    logic [3:0]   wr_idx;
    logic [3:0]   rd_sel;

    aes256_key_step u_key_step (
        .work     (work),
        .step     (step),
        .work_nxt (work_nxt)
    );

    // Each step fills an even/odd pair of round keys starting at rk[2]
    assign wr_idx = {step, 1'b0} + 4'd2;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: zeroize overrides everything, start only honoured when idle or ready
    always_comb begin
        state_nxt = state;
        if (zeroize) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_READY: if (start)     state_nxt = ST_EXPAND;
                ST_EXPAND:         if (step_last) state_nxt = ST_READY;
                default:           state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output and strobe decode from current state
    always_comb begin
        busy      = (state == ST_EXPAND);
        step_last = busy && (step == STEP_LAST);
        load      = !zeroize && start && !busy;
        expand_en = !zeroize && busy;
    end

    // Step counter restarts on every load so each run uses rcon[0..6]
    always_ff @(posedge clk) begin
        if (!rst_n)                step <= 3'd0;
        else if (zeroize || load)  step <= 3'd0;
        else if (expand_en)        step <= step_last ? 3'd0 : step + 3'd1;
    end

    // Completion pulse and validity flag; validity drops as soon as a new run begins
    always_ff @(posedge clk) begin
        if (!rst_n || zeroize) begin
            done      <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            done <= step_last;
            if (load)           key_valid <= 1'b0;
            else if (step_last) key_valid <= 1'b1;
        end
    end

    // Working key and round-key storage; not reset, only zeroize clears them
    always_ff @(posedge clk) begin
        if (zeroize) begin
            work <= '0;
            for (int i = 0; i < NRK; i++) rk[i] <= '0;
        end else if (load) begin
            work  <= key_in;
            rk[0] <= key_in[255:128];
            rk[1] <= key_in[127:0];
        end else if (expand_en) begin
            work       <= work_nxt;
            rk[wr_idx] <= work_nxt[255:128];
            if (!step_last) rk[wr_idx + 4'd1] <= work_nxt[127:0];
        end
    end

    // Read port: optional reversed order, gated to zero when invalid or out of range
    always_comb begin
        rd_key = '0;
        rd_sel = rd_rev ? (IDX_LAST - rd_idx) : rd_idx;
        if (key_valid && (rd_idx <= IDX_LAST)) rd_key = rk[rd_sel];
    end

endmodule
